// File: rtl/mem_arbiter_fsm_if.sv
// mem_arbiter_fsm_if: request, response and RAM signals around the fetch/data RAM arbiter
interface mem_arbiter_fsm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imemRen;
    logic [ADDR_W-1:0] imemaddr;
    logic              dmmRen;
    logic              dmmWen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic [DATA_W-1:0] ramload;
    logic              busy_o;
    logic              i_ready;
    logic              d_ready;
    logic              Ren;
    logic              Wen;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] imemload;
    logic [DATA_W-1:0] dmmload;

    modport slave (
        input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ramload, busy_o,
        output i_ready, d_ready, Ren, Wen, ramaddr, ramstore, imemload, dmmload
    );

    modport master (
        output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore, ramload, busy_o,
        input  i_ready, d_ready, Ren, Wen, ramaddr, ramstore, imemload, dmmload
    );
endinterface

// File: rtl/mem_arbiter_fsm.sv
// mem_arbiter_fsm: shares one single-port RAM between instruction fetch and data access
module mem_arbiter_fsm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input logic              CLK,
    input logic              nRST,
    mem_arbiter_fsm_if.slave bus
);
    localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              op_rd;
    logic              d_req;
    logic              starved;
    logic              grant_d;
    logic              grant_i;
    logic              done;

    // Grant only from IDLE and never in a ready cycle, so a finished requester can drop its request
    always_comb begin
        state_nx = state;
        d_req    = bus.dmmRen | bus.dmmWen;
        starved  = bus.imemRen && (starve_cnt == LIM);
        done     = (state != IDLE) && !bus.busy_o;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        if (state == IDLE && !bus.i_ready && !bus.d_ready) begin
            grant_d = d_req && !starved;
            grant_i = !grant_d && bus.imemRen;
        end
        if (grant_d)
            state_nx = DACC;
        else if (grant_i)
            state_nx = IACC;
        else if (done)
            state_nx = IDLE;
    end

    // RAM controls depend only on the state register and latched request, so they hold through busy
    always_comb begin
        bus.Ren      = 1'b0;
        bus.Wen      = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        if (state == IACC) begin
            bus.Ren     = 1'b1;
            bus.ramaddr = lat_addr;
        end else if (state == DACC) begin
            bus.Ren      = op_rd;
            bus.Wen      = !op_rd;
            bus.ramaddr  = lat_addr;
            bus.ramstore = op_rd ? '0 : lat_data;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Request latching, starvation tracking, ready pulses and load-data capture
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starve_cnt   <= '0;
            lat_addr     <= '0;
            lat_data     <= '0;
            op_rd        <= 1'b0;
            bus.i_ready  <= 1'b0;
            bus.d_ready  <= 1'b0;
            bus.imemload <= '0;
            bus.dmmload  <= '0;
        end else begin
            bus.i_ready <= done && (state == IACC);
            bus.d_ready <= done && (state == DACC);
            if (done && state == IACC)
                bus.imemload <= bus.ramload;
            if (done && state == DACC && op_rd)
                bus.dmmload <= bus.ramload;
            if (grant_d) begin
                lat_addr   <= bus.dmmaddr;
                lat_data   <= bus.dmmstore;
                op_rd      <= bus.dmmRen;
                starve_cnt <= !bus.imemRen ? '0 : (starve_cnt == LIM) ? starve_cnt : starve_cnt + CNT_W'(1);
            end else if (grant_i) begin
                lat_addr   <= bus.imemaddr;
                lat_data   <= '0;
                op_rd      <= 1'b1;
                starve_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb_mem_arbiter_fsm: directed scenarios with a scoreboard checking every ready pulse
module tb_mem_arbiter_fsm;
    typedef struct {
        logic        is_d;
        logic [31:0] i_ld;
        logic [31:0] d_ld;
    } exp_t;

    logic        CLK;
    logic        nRST;
    int          n_tests;
    int          n_fail;
    int          busy_plan;
    int          bcnt;
    logic        prev_act;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    exp_t        q[$];
    exp_t        e;
    string       order;
    int          w;

    mem_arbiter_fsm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter_fsm #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a == 32'h80) ? 32'hCAFEF00D : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input logic is_d);
        exp_t x;
        x.is_d = is_d;
        x.i_ld = exp_i;
        x.d_ld = exp_d;
        q.push_back(x);
    endtask

    task automatic wait_ready(input logic want_d, input int exp_ticks, input string name);
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!(want_d ? bus.d_ready : bus.i_ready) && t < 20);
        check(name, t, exp_ticks);
    endtask

    // RAM model: content is a function of address, busy for busy_plan cycles at the start of each access
    initial begin
        bus.busy_o  = 1'b0;
        bus.ramload = '0;
        prev_act    = 1'b0;
        bcnt        = 0;
        forever begin
            @(negedge CLK);
            if ((bus.Ren || bus.Wen) && !prev_act)
                bcnt = busy_plan;
            prev_act   = bus.Ren || bus.Wen;
            bus.busy_o = prev_act && (bcnt > 0);
            if (bus.busy_o)
                bcnt--;
            bus.ramload = ram_val(bus.ramaddr);
        end
    end

    // Monitor: exclusivity invariants every cycle, scoreboard pop on every ready pulse
    always @(negedge CLK) begin
        check("excl_ready", 32'(bus.i_ready && bus.d_ready), 32'd0);
        check("excl_ren_wen", 32'(bus.Ren && bus.Wen), 32'd0);
        if (bus.i_ready || bus.d_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got i_ready=%0b d_ready=%0b expected none", bus.i_ready, bus.d_ready);
            end else begin
                e = q.pop_front();
                check("ready_kind", 32'(bus.d_ready), 32'(e.is_d));
                check("imemload", bus.imemload, e.i_ld);
                check("dmmload", bus.dmmload, e.d_ld);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        busy_plan = 0;
        exp_i = '0;
        exp_d = '0;
        nRST = 1'b0;
        bus.imemRen = 1'b0;
        bus.imemaddr = '0;
        bus.dmmRen = 1'b0;
        bus.dmmWen = 1'b0;
        bus.dmmaddr = '0;
        bus.dmmstore = '0;
        repeat (3) tick();
        check("rst_ren", 32'(bus.Ren), 0);
        check("rst_wen", 32'(bus.Wen), 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_iload", bus.imemload, 0);
        check("rst_dload", bus.dmmload, 0);
        nRST = 1'b1;
        tick();

        // Fetch with zero wait
        bus.imemRen = 1'b1;
        bus.imemaddr = 32'h100;
        busy_plan = 0;
        exp_i = 32'hDEADBEEF;
        push(1'b0);
        tick();
        check("f_ren", 32'(bus.Ren), 1);
        check("f_wen", 32'(bus.Wen), 0);
        check("f_addr", bus.ramaddr, 32'h100);
        tick();
        check("f_iready", 32'(bus.i_ready), 1);
        check("f_bubble_ren", 32'(bus.Ren), 0);
        bus.imemRen = 1'b0;
        tick();
        check("f_pulse_end", 32'(bus.i_ready), 0);

        // Read-modify-write conflict: read wins
        bus.dmmRen = 1'b1;
        bus.dmmWen = 1'b1;
        bus.dmmaddr = 32'h80;
        bus.dmmstore = 32'h7777;
        busy_plan = 0;
        exp_d = 32'hCAFEF00D;
        push(1'b1);
        tick();
        check("rw_ren", 32'(bus.Ren), 1);
        check("rw_wen", 32'(bus.Wen), 0);
        check("rw_addr", bus.ramaddr, 32'h80);
        check("rw_store", bus.ramstore, 0);
        tick();
        check("rw_dready", 32'(bus.d_ready), 1);
        bus.dmmRen = 1'b0;
        bus.dmmWen = 1'b0;
        tick();

        // Write with three busy cycles; dmmload must keep the previous read value
        bus.dmmWen = 1'b1;
        bus.dmmaddr = 32'h40;
        bus.dmmstore = 32'h1234;
        busy_plan = 3;
        push(1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2)
                bus.dmmstore = 32'hFFFF;
            check($sformatf("w_wen%0d", k), 32'(bus.Wen), 1);
            check($sformatf("w_ren%0d", k), 32'(bus.Ren), 0);
            check($sformatf("w_addr%0d", k), bus.ramaddr, 32'h40);
            check($sformatf("w_store%0d", k), bus.ramstore, 32'h1234);
        end
        tick();
        check("w_dready", 32'(bus.d_ready), 1);
        bus.dmmWen = 1'b0;
        tick();

        // Fetch request dropped while the RAM is busy
        bus.imemRen = 1'b1;
        bus.imemaddr = 32'h180;
        busy_plan = 2;
        exp_i = ram_val(32'h180);
        push(1'b0);
        tick();
        check("drop_addr", bus.ramaddr, 32'h180);
        bus.imemRen = 1'b0;
        wait_ready(1'b0, 3, "drop_latency");
        tick();
        check("drop_no_regrant", 32'(bus.Ren), 0);
        check("drop_single_pulse", 32'(bus.i_ready), 0);
        tick();

        // Contention: data wins until the starvation limit forces a fetch
        order = "DDDDID";
        bus.imemRen = 1'b1;
        bus.imemaddr = 32'h200;
        bus.dmmRen = 1'b1;
        bus.dmmaddr = 32'h300;
        busy_plan = 0;
        for (int g = 0; g < 6; g++) begin
            if (order[g] == "D")
                exp_d = ram_val(32'h300);
            else
                exp_i = ram_val(32'h200);
            push(order[g] == "D");
        end
        for (int g = 0; g < 6; g++) begin
            w = 0;
            do begin
                tick();
                w++;
            end while (!(bus.Ren || bus.Wen) && w < 20);
            check($sformatf("grant%0d", g), bus.ramaddr, (order[g] == "D") ? 32'h300 : 32'h200);
            if (g == 3)
                check("starve_at_lim", 32'(dut.starve_cnt), 4);
            if (g == 4) begin
                check("starve_cleared", 32'(dut.starve_cnt), 0);
                tick();
                check("forced_iready", 32'(bus.i_ready), 1);
                bus.imemRen = 1'b0;
            end
        end
        tick();
        check("last_dready", 32'(bus.d_ready), 1);
        bus.dmmRen = 1'b0;
        tick();

        // Reset in the middle of a stalled write
        bus.dmmWen = 1'b1;
        bus.dmmaddr = 32'h44;
        bus.dmmstore = 32'h99;
        busy_plan = 100;
        tick();
        check("rm_wen", 32'(bus.Wen), 1);
        tick();
        nRST = 1'b0;
        tick();
        check("rm_ren", 32'(bus.Ren), 0);
        check("rm_wen0", 32'(bus.Wen), 0);
        check("rm_addr", bus.ramaddr, 0);
        check("rm_store", bus.ramstore, 0);
        check("rm_dready", 32'(bus.d_ready), 0);
        check("rm_iload", bus.imemload, 0);
        check("rm_dload", bus.dmmload, 0);
        check("rm_starve", 32'(dut.starve_cnt), 0);
        bus.dmmWen = 1'b0;
        busy_plan = 0;
        nRST = 1'b1;
        tick();
        check("rm_no_pulse", 32'(bus.d_ready), 0);
        tick();
        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
